// File: rtl/two_port_ram_pkg.sv
// Shared defaults and word/address types for the two_port_ram dual-port memory.
package two_port_ram_pkg;

   localparam int unsigned DATA_W_DEFAULT = 8;
   localparam int unsigned ADDR_W_DEFAULT = 6;
   localparam int unsigned DEPTH_DEFAULT  = 2 ** ADDR_W_DEFAULT;

   typedef logic [DATA_W_DEFAULT-1:0] data_t;
   typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

endpackage : two_port_ram_pkg

// File: rtl/two_port_ram_fwd.sv
// Write-collision resolution (port A has priority) and read-data selection per port.
// Build with TWO_PORT_RAM_WRITE_THROUGH_EN for write-first forwarding; default is read-first.
module two_port_ram_fwd
   import two_port_ram_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              we_a_i,
   input  logic              we_b_i,
   input  logic [ADDR_W-1:0] addr_a_i,
   input  logic [ADDR_W-1:0] addr_b_i,
   input  logic [DATA_W-1:0] data_a_i,
   input  logic [DATA_W-1:0] data_b_i,
   input  logic [DATA_W-1:0] rdata_a_i,
   input  logic [DATA_W-1:0] rdata_b_i,
   output logic              wr_en_a_o,
   output logic              wr_en_b_o,
   output logic [DATA_W-1:0] wr_data_a_o,
   output logic [DATA_W-1:0] wr_data_b_o,
   output logic [DATA_W-1:0] fwd_a_o,
   output logic [DATA_W-1:0] fwd_b_o
);

   logic collide;

   // Same-address double write: B is dropped so the array always holds data_a.
   assign collide     = we_a_i && we_b_i && (addr_a_i == addr_b_i);
   assign wr_en_a_o   = we_a_i;
   assign wr_en_b_o   = we_b_i && !collide;
   assign wr_data_a_o = data_a_i;
   assign wr_data_b_o = data_b_i;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      fwd_a_o = rdata_a_i;
      fwd_b_o = rdata_b_i;
`ifdef TWO_PORT_RAM_WRITE_THROUGH_EN
      // A is applied last so it overrides B, mirroring what lands in the array.
      if (wr_en_b_o && (addr_b_i == addr_a_i)) fwd_a_o = data_b_i;
      if (we_a_i) fwd_a_o = data_a_i;
      if (wr_en_b_o) fwd_b_o = data_b_i;
      if (we_a_i && (addr_a_i == addr_b_i)) fwd_b_o = data_a_i;
`endif
   end

endmodule : two_port_ram_fwd

// File: rtl/two_port_ram.sv
// True dual-port synchronous RAM with registered read outputs and A-priority writes.
// Optional macro TWO_PORT_RAM_WRITE_THROUGH_EN selects write-first reads (default read-first).
module two_port_ram
   import two_port_ram_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic              rd_a,
   input  logic              rd_b,
   output logic [DATA_W-1:0] qa,
   output logic [DATA_W-1:0] qb
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] qa_q, qa_d;
   logic [DATA_W-1:0] qb_q, qb_d;
   logic              wr_en_a, wr_en_b;
   logic [DATA_W-1:0] wr_data_a, wr_data_b;
   logic [DATA_W-1:0] fwd_a, fwd_b;

   two_port_ram_fwd #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_fwd (
      .we_a_i      (we_a),
      .we_b_i      (we_b),
      .addr_a_i    (addr_a),
      .addr_b_i    (addr_b),
      .data_a_i    (data_a),
      .data_b_i    (data_b),
      .rdata_a_i   (mem_q[addr_a]),
      .rdata_b_i   (mem_q[addr_b]),
      .wr_en_a_o   (wr_en_a),
      .wr_en_b_o   (wr_en_b),
      .wr_data_a_o (wr_data_a),
      .wr_data_b_o (wr_data_b),
      .fwd_a_o     (fwd_a),
      .fwd_b_o     (fwd_b)
   );

   // NOTE: the array has no reset branch so it maps onto block RAM; reset only gates writes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wr_en_a) mem_q[addr_a] <= wr_data_a;
         if (wr_en_b) mem_q[addr_b] <= wr_data_b;
      end
   end

   assign qa_d = rd_a ? fwd_a : qa_q;
   assign qb_d = rd_b ? fwd_b : qb_q;

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         qa_q <= '0;
         qb_q <= '0;
      end else begin
         qa_q <= qa_d;
         qb_q <= qb_d;
      end
   end

   assign qa = qa_q;
   assign qb = qb_q;

endmodule : two_port_ram

// File: tb/tb_two_port_ram.sv
// Self-checking bench for two_port_ram: directed scenarios plus randomized traffic vs. an array model.
module tb_two_port_ram;
   import two_port_ram_pkg::*;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   data_t data_a = '0, data_b = '0;
   addr_t addr_a = '0, addr_b = '0;
   logic  we_a = 1'b0, we_b = 1'b0, rd_a = 1'b0, rd_b = 1'b0;
   data_t qa, qb;

   int total = 0;
   int bad   = 0;

   data_t m_mem [DEPTH_DEFAULT];
   data_t m_qa = '0;
   data_t m_qb = '0;

`ifdef TWO_PORT_RAM_WRITE_THROUGH_EN
   localparam data_t RDW_EXP = 8'h44;
`else
   localparam data_t RDW_EXP = 8'h33;
`endif

   two_port_ram dut (
      .clk    (clk),
      .rst    (rst),
      .data_a (data_a),
      .data_b (data_b),
      .addr_a (addr_a),
      .addr_b (addr_b),
      .we_a   (we_a),
      .we_b   (we_b),
      .rd_a   (rd_a),
      .rd_b   (rd_b),
      .qa     (qa),
      .qb     (qb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input data_t got, input data_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%02h expected=%02h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, update the model at the edge, compare both outputs 1ns later.
   task automatic cyc(input logic r,
                      input logic wa, input addr_t aa, input data_t da, input logic ra,
                      input logic wb, input addr_t ab, input data_t db, input logic rb);
      data_t old_a, old_b;
      rst = r; we_a = wa; addr_a = aa; data_a = da; rd_a = ra;
      we_b = wb; addr_b = ab; data_b = db; rd_b = rb;
      @(posedge clk);
      if (r) begin
         m_qa = '0;
         m_qb = '0;
      end else begin
         old_a = m_mem[aa];
         old_b = m_mem[ab];
         if (wb) m_mem[ab] = db;
         if (wa) m_mem[aa] = da;
`ifdef TWO_PORT_RAM_WRITE_THROUGH_EN
         if (ra) m_qa = m_mem[aa];
         if (rb) m_qb = m_mem[ab];
`else
         if (ra) m_qa = old_a;
         if (rb) m_qb = old_b;
`endif
      end
      #1;
      check("qa_model", qa, m_qa);
      check("qb_model", qb, m_qb);
   endtask

   initial begin
      // Reset
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("reset_qa", qa, 8'h00);
      check("reset_qb", qb, 8'h00);

      // Fill every word so no read ever sees uninitialised storage
      for (int i = 0; i < DEPTH_DEFAULT / 2; i++)
         cyc(0, 1, addr_t'(i), data_t'($urandom), 0,
                1, addr_t'(i + DEPTH_DEFAULT / 2), data_t'($urandom), 0);

      // Dual writes then dual reads
      for (int i = 0; i < 3; i++) cyc(0, 1, 3, 8'h11, 0, 1, 6, 8'h01, 0);
      cyc(0, 0, 3, 0, 1, 0, 6, 0, 1);
      check("rd_a3", qa, 8'h11);
      check("rd_b6", qb, 8'h01);

      // Cross-port read
      cyc(0, 1, 10, 8'hAA, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 10, 0, 1);
      check("xport_b10", qb, 8'hAA);
      cyc(0, 0, 6, 0, 1, 0, 3, 0, 1);
      check("xport_a6", qa, 8'h01);
      check("xport_b3", qb, 8'h11);

      // Write collision: A wins
      cyc(0, 1, 20, 8'h5A, 0, 1, 20, 8'hA5, 0);
      cyc(0, 0, 20, 0, 1, 0, 20, 0, 1);
      check("coll_a", qa, 8'h5A);
      check("coll_b", qb, 8'h5A);

      // Read during write from the other port
      cyc(0, 1, 7, 8'h33, 0, 0, 0, 0, 0);
      cyc(0, 1, 7, 8'h44, 0, 0, 7, 0, 1);
      check("rdw_b7", qb, RDW_EXP);
      cyc(0, 0, 0, 0, 0, 0, 7, 0, 1);
      check("rdw_next_b7", qb, 8'h44);

      // Hold: qa keeps the collision read while A writes elsewhere
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, addr_t'(40 + i), data_t'($urandom), 0, 0, 0, 0, 1);
         check("hold_qa", qa, 8'h5A);
      end

      // Reset clears outputs but not memory
      cyc(1, 1, 3, 8'hFF, 1, 1, 6, 8'hFF, 1);
      check("rst2_qa", qa, 8'h00);
      check("rst2_qb", qb, 8'h00);
      cyc(0, 0, 3, 0, 1, 0, 6, 0, 1);
      check("survive_a3", qa, 8'h11);
      check("survive_b6", qb, 8'h01);

      // Random traffic, biased toward a few addresses to provoke collisions
      for (int i = 0; i < 800; i++) begin
         logic  narrow;
         addr_t ra_addr, rb_addr;
         narrow  = ($urandom_range(0, 1) == 1);
         ra_addr = narrow ? addr_t'($urandom_range(0, 3)) : addr_t'($urandom);
         rb_addr = narrow ? addr_t'($urandom_range(0, 3)) : addr_t'($urandom);
         cyc(($urandom_range(0, 31) == 0),
             1'($urandom), ra_addr, data_t'($urandom), 1'($urandom),
             1'($urandom), rb_addr, data_t'($urandom), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_two_port_ram
